// File: rtl/debug_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module : debug_trace_fifo
// Debug trace monitor: DCP config decode, core event detect, packet serialiser
// and 32-bit trace FIFO drained by valid/ready.
// Rev    : 1.0
// ============================================================================
module debug_trace_fifo #(
    parameter int DATA_W     = 128,
    parameter int NCFG       = 4,
    parameter int CFG_BASE   = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              MRST,
    input  logic [31:0]       DCP,
    input  logic [1:0]        Sel,
    input  logic              mode,
    input  logic              ld,
    input  logic              done,
    input  logic              pause,
    input  logic [DATA_W-1:0] key,
    input  logic [DATA_W-1:0] t_in,
    input  logic [DATA_W-1:0] t_out,
    output logic [7:0]        EV,
    output logic [31:0]       Val,
    output logic [31:0]       TP,
    output logic              TPE,
    input  logic              TP_rdy,
    output logic              ovf
);
    localparam int c_nw = DATA_W / 32;
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_iw = (NCFG > 1) ? $clog2(NCFG) : 1;
    localparam int c_lw = $clog2(c_nw + 1);
    localparam logic [7:0]    c_base  = CFG_BASE[7:0];
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_hdr  = 2'd1;
    localparam logic [1:0] c_pay  = 2'd2;

    logic [7:0]        r_addr;
    logic [1:0]        r_sel;
    logic              r_wr_pend;
    logic [31:0]       r_cfr [NCFG];
    logic              r_ld_q, r_done_q, r_pause_q, r_busy, r_armed;
    logic [31:0]       r_cyc_cnt, r_pcnt;
    logic [15:0]       r_ts, r_drop;
    logic [7:0]        r_ev;
    logic              r_ovf;
    logic [1:0]        r_state;
    logic [31:0]       r_hdr;
    logic [DATA_W-1:0] r_snap;
    logic [c_lw-1:0]   r_left;
    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]     r_count;

    logic [7:0]        w_idx, w_code;
    logic              w_cfg_wr, w_cfr0_wr;
    logic              w_ld_rise, w_done_rise, w_pause_rise, w_pause_fall;
    logic              w_cond, w_fire, w_accept, w_drop, w_push, w_pop;
    logic [c_lw-1:0]   w_len;
    logic [DATA_W-1:0] w_payload;
    logic [c_aw:0]     w_free, w_need;
    logic [31:0]       w_push_data;
    logic              w_unused;

    // Unsigned wrap makes addresses below the base land outside the range too.
    assign w_idx     = r_addr - c_base;
    assign w_cfg_wr  = r_wr_pend && (w_idx < 8'(NCFG));
    assign w_cfr0_wr = w_cfg_wr && (w_idx == 8'd0);

    always_ff @(posedge clk or negedge MRST) begin
        if (!MRST) begin
            r_addr    <= '0;
            r_sel     <= '0;
            r_wr_pend <= 1'b0;
            for (int i = 0; i < NCFG; i++) r_cfr[i] <= '0;
        end else if (r_wr_pend) begin
            r_wr_pend <= 1'b0;
            if (w_cfg_wr) r_cfr[w_idx[c_iw-1:0]] <= DCP;
        end else if (DCP[31]) begin
            r_addr    <= DCP[7:0];
            r_sel     <= Sel;
            r_wr_pend <= 1'b1;
        end
    end

    assign w_ld_rise    = ld & ~r_ld_q;
    assign w_done_rise  = done & ~r_done_q;
    assign w_pause_rise = pause & ~r_pause_q;
    assign w_pause_fall = ~pause & r_pause_q;

    always_ff @(posedge clk or negedge MRST) begin
        if (!MRST) begin
            r_ld_q    <= 1'b0;
            r_done_q  <= 1'b0;
            r_pause_q <= 1'b0;
            r_busy    <= 1'b0;
            r_cyc_cnt <= '0;
            r_pcnt    <= '0;
            r_ts      <= '0;
        end else begin
            r_ld_q    <= ld;
            r_done_q  <= done;
            r_pause_q <= pause;
            r_ts      <= r_ts + 16'd1;
            if (w_ld_rise)        r_busy <= 1'b1;
            else if (w_done_rise) r_busy <= 1'b0;
            if (w_ld_rise) begin
                r_cyc_cnt <= '0;
                r_pcnt    <= '0;
            end else if (r_busy) begin
                if (!pause && (r_cyc_cnt != '1)) r_cyc_cnt <= r_cyc_cnt + 32'd1;
                if (pause && (r_pcnt != '1))     r_pcnt    <= r_pcnt + 32'd1;
            end
        end
    end

    assign w_code = r_cfr[0][7:0];

    always_comb begin
        w_cond    = 1'b0;
        w_len     = c_lw'(c_nw);
        w_payload = t_out;
        case (w_code)
            8'd1: begin w_cond = w_done_rise; w_len = c_lw'(1); w_payload = DATA_W'(r_cyc_cnt); end
            8'd2: begin w_cond = w_ld_rise & mode;  w_payload = key; end
            8'd3: begin w_cond = w_ld_rise & ~mode; w_payload = key; end
            8'd4: begin w_cond = w_ld_rise; w_payload = t_in; end
            8'd5: begin w_cond = w_done_rise; end
            8'd6: begin w_cond = r_busy & w_pause_rise; w_len = '0; w_payload = '0; end
            8'd7: begin w_cond = r_busy & w_pause_fall; w_len = c_lw'(1); w_payload = DATA_W'(r_pcnt); end
            8'd8: begin w_cond = r_busy && (r_cyc_cnt == r_cfr[1]); end
            default: w_cond = 1'b0;
        endcase
    end

    // Whole packet space is reserved up front, so pushes never meet a full FIFO.
    assign w_fire   = r_armed & w_cond;
    assign w_free   = c_depth - r_count;
    assign w_need   = (c_aw + 1)'(w_len) + (c_aw + 1)'(1);
    assign w_accept = w_fire && (r_state == c_idle) && (w_free >= w_need);
    assign w_drop   = w_fire && !w_accept;

    always_ff @(posedge clk or negedge MRST) begin
        if (!MRST) begin
            r_armed <= 1'b0;
            r_ev    <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= '0;
        end else if (w_cfr0_wr) begin
            r_armed <= 1'b1;
            r_ev    <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= '0;
        end else begin
            if (w_accept) begin
                r_ev <= w_code;
                if (!r_cfr[0][8]) r_armed <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop != '1) r_drop <= r_drop + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge MRST) begin
        if (!MRST) begin
            r_state <= c_idle;
            r_hdr   <= '0;
            r_snap  <= '0;
            r_left  <= '0;
        end else begin
            case (r_state)
                c_idle: if (w_accept) begin
                    r_hdr   <= {8'hA5, w_code, r_ts};
                    r_snap  <= w_payload;
                    r_left  <= w_len;
                    r_state <= c_hdr;
                end
                c_hdr: r_state <= (r_left == '0) ? c_idle : c_pay;
                c_pay: begin
                    r_snap <= r_snap >> 32;
                    r_left <= r_left - c_lw'(1);
                    if (r_left == c_lw'(1)) r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign w_push      = (r_state == c_hdr) || (r_state == c_pay);
    assign w_push_data = (r_state == c_hdr) ? r_hdr : r_snap[31:0];
    assign w_pop       = TPE & TP_rdy;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk or negedge MRST) begin
        if (!MRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign TPE = (r_count != '0);
    assign TP  = TPE ? r_mem[r_rd_ptr] : 32'd0;
    assign Val = {r_drop, 16'(r_count)};
    assign EV  = r_ev;
    assign ovf = r_ovf;

    // Requester id and spare config bits are held for the debug fabric only.
    always_comb begin
        w_unused = ^{r_sel, r_cfr[0][31:9]};
        for (int i = 2; i < NCFG; i++) w_unused = w_unused ^ (^r_cfr[i]);
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_debug_trace_fifo
// Self-checking bench for debug_trace_fifo: event table plus corner sequences.
// Rev    : 1.0
// ============================================================================
module tb_debug_trace_fifo;
    localparam int DATA_W     = 128;
    localparam int NCFG       = 4;
    localparam int CFG_BASE   = 32;
    localparam int FIFO_DEPTH = 16;
    localparam logic [127:0] KEY  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] TIN  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] TOUT = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam int AT_NONE = 0, AT_LD = 1, AT_PR = 2, AT_PF = 3, AT_DONE = 4;

    typedef struct {
        logic [31:0]  cfr0;
        logic         mode;
        int           at;
        int           nw;
        logic [127:0] pay;
        logic [7:0]   ev;
    } vec_t;

    logic              clk = 1'b0;
    logic              MRST;
    logic [31:0]       DCP;
    logic [1:0]        Sel;
    logic              mode, ld, done, pause, TP_rdy;
    logic [DATA_W-1:0] key, t_in, t_out;
    logic [7:0]        EV;
    logic [31:0]       Val, TP;
    logic              TPE, ovf;

    always #5 clk = ~clk;

    debug_trace_fifo #(
        .DATA_W(DATA_W), .NCFG(NCFG), .CFG_BASE(CFG_BASE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .MRST(MRST), .DCP(DCP), .Sel(Sel), .mode(mode), .ld(ld),
        .done(done), .pause(pause), .key(key), .t_in(t_in), .t_out(t_out),
        .EV(EV), .Val(Val), .TP(TP), .TPE(TPE), .TP_rdy(TP_rdy), .ovf(ovf)
    );

    logic [15:0] tb_ts;
    logic [31:0] sb [$];
    int n_checks = 0;
    int n_fail   = 0;

    always @(posedge clk or negedge MRST) begin
        if (!MRST) tb_ts <= 16'd0;
        else       tb_ts <= tb_ts + 16'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (MRST === 1'b1 && TPE === 1'b1 && TP_rdy === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL trace_word: got %h expected no word", TP);
            end else begin
                e = sb.pop_front();
                check("trace_word", TP, e);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [31:0] data);
        DCP = {24'h800000, addr};
        tick();
        DCP = data;
        tick();
        DCP = 32'd0;
    endtask

    task automatic expect_packet(input logic [7:0] code, input int nw, input logic [127:0] pay);
        sb.push_back({8'hA5, code, tb_ts});
        for (int i = 0; i < nw; i++) sb.push_back(pay[32*i +: 32]);
    endtask

    // One core operation: ld rise, 2 run cycles, 3 paused, 2 run, done rise.
    task automatic run_op(input int at, input logic [7:0] code, input int nw, input logic [127:0] pay);
        ld = 1'b1;
        if (at == AT_LD) expect_packet(code, nw, pay);
        tick(); ld = 1'b0; tick(); tick();
        pause = 1'b1;
        if (at == AT_PR) expect_packet(code, nw, pay);
        repeat (3) tick();
        pause = 1'b0;
        if (at == AT_PF) expect_packet(code, nw, pay);
        tick(); tick();
        done = 1'b1;
        if (at == AT_DONE) expect_packet(code, nw, pay);
        tick(); done = 1'b0; tick();
    endtask

    task automatic drain;
        int i;
        i = 0;
        while (sb.size() != 0 && i < 100) begin
            tick();
            i++;
        end
        tick();
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [10];
        logic [31:0] hold;

        MRST = 1'b0; DCP = '0; Sel = 2'd2; mode = 1'b0; ld = 1'b0; done = 1'b0;
        pause = 1'b0; key = KEY; t_in = TIN; t_out = TOUT; TP_rdy = 1'b1;

        tbl[0] = '{32'h102, 1'b1, AT_LD,   4, KEY,       8'd2};
        tbl[1] = '{32'h102, 1'b0, AT_NONE, 0, '0,        8'd0};
        tbl[2] = '{32'h103, 1'b0, AT_LD,   4, KEY,       8'd3};
        tbl[3] = '{32'h104, 1'b1, AT_LD,   4, TIN,       8'd4};
        tbl[4] = '{32'h105, 1'b0, AT_DONE, 4, TOUT,      8'd5};
        tbl[5] = '{32'h101, 1'b0, AT_DONE, 1, 128'd4,    8'd1};
        tbl[6] = '{32'h106, 1'b0, AT_PR,   0, '0,        8'd6};
        tbl[7] = '{32'h107, 1'b0, AT_PF,   1, 128'd3,    8'd7};
        tbl[8] = '{32'h000, 1'b1, AT_NONE, 0, '0,        8'd0};
        tbl[9] = '{32'h003, 1'b0, AT_LD,   4, KEY,       8'd3};

        repeat (3) @(posedge clk);
        #1;
        check("reset_TPE", {31'd0, TPE}, 32'd0);
        check("reset_TP", TP, 32'd0);
        check("reset_EV", {24'd0, EV}, 32'd0);
        check("reset_Val", Val, 32'd0);
        check("reset_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk) MRST = 1'b1;
        tick();

        // Config decode: in-range write takes, out-of-range writes are ignored.
        cfg_write(8'h20, 32'h0000_0105);
        cfg_write(8'h10, 32'h0000_0101);
        cfg_write(8'h24, 32'h0000_0101);
        mode = 1'b0;
        run_op(AT_DONE, 8'd5, 4, TOUT);
        drain();
        check("cfg_ev", {24'd0, EV}, 32'd5);

        for (int i = 0; i < 10; i++) begin
            mode = tbl[i].mode;
            cfg_write(8'(CFG_BASE), tbl[i].cfr0);
            run_op(tbl[i].at, tbl[i].cfr0[7:0], tbl[i].nw, tbl[i].pay);
            drain();
            check($sformatf("vec%0d_ev", i), {24'd0, EV}, {24'd0, tbl[i].ev});
            check($sformatf("vec%0d_status", i), Val, 32'd0);
        end

        // Cycle-count trigger, one-shot.
        cfg_write(8'h21, 32'd10);
        cfg_write(8'h20, 32'h0000_0008);
        ld = 1'b1; tick(); ld = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            pause = (c >= 5 && c <= 7);
            if (c == 14) expect_packet(8'd8, 4, TOUT);
            tick();
        end
        done = 1'b1; tick(); done = 1'b0; tick();
        ld = 1'b1; tick(); ld = 1'b0;
        repeat (20) tick();
        done = 1'b1; tick(); done = 1'b0;
        drain();
        check("cyc_ev", {24'd0, EV}, 32'd8);
        check("cyc_status", Val, 32'd0);

        // Overflow: three packets fit, the fourth drops.
        TP_rdy = 1'b0;
        cfg_write(8'h20, 32'h0000_0105);
        for (int k = 0; k < 4; k++) begin
            done = 1'b1;
            if (k < 3) expect_packet(8'd5, 4, TOUT);
            tick(); done = 1'b0;
            repeat (7) tick();
        end
        check("ovf_status", Val, 32'h0001_000F);
        check("ovf_flag", {31'd0, ovf}, 32'd1);
        check("ovf_ev", {24'd0, EV}, 32'd5);
        hold = TP;
        check("stall_head", TP, sb[0]);
        repeat (5) tick();
        check("stall_stable", TP, hold);
        TP_rdy = 1'b1;
        drain();
        check("ovf_after_drain", Val, 32'h0001_0000);

        // Back-pressure toggling during payload.
        cfg_write(8'h20, 32'h0000_0104);
        ld = 1'b1;
        expect_packet(8'd4, 4, TIN);
        tick(); ld = 1'b0;
        for (int c = 0; c < 16; c++) begin
            TP_rdy = (c % 2 == 1);
            tick();
        end
        TP_rdy = 1'b1;
        drain();
        check("bp_status", Val, 32'd0);
        check("bp_ev", {24'd0, EV}, 32'd4);

        // Asynchronous reset in the middle of a packet.
        cfg_write(8'h20, 32'h0000_0102);
        mode = 1'b1; TP_rdy = 1'b0;
        ld = 1'b1;
        expect_packet(8'd2, 4, KEY);
        tick(); ld = 1'b0; tick(); tick();
        check("mid_TPE", {31'd0, TPE}, 32'd1);
        check("mid_level", Val, 32'd2);
        check("mid_ev", {24'd0, EV}, 32'd2);
        #2 MRST = 1'b0;
        #1;
        check("async_TPE", {31'd0, TPE}, 32'd0);
        check("async_TP", TP, 32'd0);
        check("async_EV", {24'd0, EV}, 32'd0);
        check("async_Val", Val, 32'd0);
        check("async_ovf", {31'd0, ovf}, 32'd0);
        sb.delete();
        @(negedge clk) MRST = 1'b1;
        TP_rdy = 1'b1;
        ld = 1'b0; tick();
        ld = 1'b1; tick(); ld = 1'b0;
        repeat (6) tick();
        check("post_reset_TPE", {31'd0, TPE}, 32'd0);
        check("post_reset_Val", Val, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
